// File: rtl/stim_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : stim_pattern_gen_if
//  Description : Control, handshake and status bundle for stim_pattern_gen.
//                The generator drives the master modport, and the bench or
//                sink drives the slave modport. When STIM_CHECKSUM_EN is
//                defined, the bundle also carries the running checksum.
//  Revision    : 1.0  initial release
// ============================================================================
interface stim_pattern_gen_if #(
  parameter int WIDTH = 8
);

  // Sweep control, sampled by the generator only on start
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;

  // Stream handshake
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  // Sweep status
  logic             busy;
  logic             done;
  logic             wrap;
  logic [31:0]      vec_cnt;

`ifdef STIM_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  // Generator side
  modport master (
    input  start,
    input  mode,
    input  seed,
    input  out_ready,
    output out_data,
    output out_valid,
    output busy,
    output done,
    output wrap,
    output vec_cnt
`ifdef STIM_CHECKSUM_EN
    , output checksum
`endif
  );

  // Bench / sink side
  modport slave (
    output start,
    output mode,
    output seed,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  busy,
    input  done,
    input  wrap,
    input  vec_cnt
`ifdef STIM_CHECKSUM_EN
    , input checksum
`endif
  );

endinterface
`default_nettype wire

// File: rtl/stim_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : stim_pattern_gen
//  Description : Handshaked stimulus source for combinational DUT benches.
//                It sweeps WIDTH-bit vectors in one of four modes: up-count,
//                down-count, Galois LFSR or Gray code. The sweep is either
//                bounded to NUM_VEC vectors or free-running (NUM_VEC = 0).
//                The pattern advances only on accepted transfers.
//                Optional feature: define STIM_CHECKSUM_EN to add a checksum
//                output. The checksum is the sum of accepted vectors mod
//                2^WIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module stim_pattern_gen #(
  parameter int               WIDTH   = 8,
  parameter int               NUM_VEC = 0,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(8'hB8)
) (
  input  wire logic           clk,
  input  wire logic           rst,
  stim_pattern_gen_if.master  bus
);

  // Mode encodings as seen on bus.mode
  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;
  localparam logic [1:0] MODE_GRAY = 2'b11;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]      CNT_MAX  = 32'hFFFF_FFFF;
  // Value of vec_cnt at the final accept of a bounded sweep (unused when free-running)
  localparam logic [31:0]      LAST_CNT = (NUM_VEC == 0) ? 32'd0 : 32'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_val;        // internal sweep register
  logic [WIDTH-1:0] r_first;      // value loaded at start; LFSR period reference
  logic [1:0]       r_mode;       // mode latched at start
  logic [31:0]      r_vec_cnt;
  logic             r_wrap;

  logic [WIDTH-1:0] w_val_nxt;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_out_data;
  logic             w_wrap_hit;
  logic             w_accept;
  logic             w_start_ok;
  logic             w_last;

  // A transfer happens only while valid (RUN) meets ready
  assign w_accept   = (r_state == ST_RUN) && bus.out_ready;
  // start is honoured outside RUN only
  assign w_start_ok = bus.start && (r_state != ST_RUN);
  // Final accept of a bounded sweep
  assign w_last     = (NUM_VEC != 0) && (r_vec_cnt == LAST_CNT);

  // An all-zero LFSR would never move, so a zero LFSR seed is replaced by 1
  assign w_load_val = ((bus.mode == MODE_LFSR) && (bus.seed == '0)) ? ONE : bus.seed;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Successor value and end-of-period detect for the latched mode
  always_comb begin
    w_val_nxt  = r_val;
    w_wrap_hit = 1'b0;
    case (r_mode)
      MODE_DOWN: begin
        w_val_nxt  = r_val - ONE;
        w_wrap_hit = (r_val == '0);
      end
      MODE_LFSR: begin
        w_val_nxt  = (r_val >> 1) ^ (r_val[0] ? TAPS : '0);
        // The period closes when the sequence returns to its loaded value
        w_wrap_hit = (w_val_nxt == r_first);
      end
      default: begin
        // UP and GRAY share a binary counter, and only the output map differs
        w_val_nxt  = r_val + ONE;
        w_wrap_hit = &r_val;
      end
    endcase
  end

  // Sweep datapath: load on start, advance on accept, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val     <= '0;
      r_first   <= '0;
      r_mode    <= MODE_UP;
      r_vec_cnt <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= w_accept && w_wrap_hit;
      if (w_start_ok) begin
        r_val     <= w_load_val;
        r_first   <= w_load_val;
        r_mode    <= bus.mode;
        r_vec_cnt <= '0;
      end else if (w_accept) begin
        r_val <= w_val_nxt;
        if (r_vec_cnt != CNT_MAX) begin
          r_vec_cnt <= r_vec_cnt + 32'd1;
        end
      end
    end
  end

  // Gray mode presents the reflected code of the internal counter
  assign w_out_data = (r_mode == MODE_GRAY) ? (r_val ^ (r_val >> 1)) : r_val;

  assign bus.out_data  = w_out_data;
  assign bus.out_valid = (r_state == ST_RUN);
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.wrap      = r_wrap;
  assign bus.vec_cnt   = r_vec_cnt;

`ifdef STIM_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;

  // Running sum of accepted vectors, restarted with each sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + w_out_data;
    end
  end

  assign bus.checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stim_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stim_pattern_gen
//  Description : Self-checking bench for stim_pattern_gen. It uses two
//                instances: dut0 is free-running, and dut1 is bounded to
//                four vectors per sweep. A sequence-level reference model is
//                compared against both instances on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stim_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       start_v [2];
  logic [1:0] mode_v  [2];
  logic [7:0] seed_v  [2];
  logic       ready_v [2];

  stim_pattern_gen_if #(.WIDTH(8)) bus0 ();
  stim_pattern_gen_if #(.WIDTH(8)) bus1 ();

  assign bus0.start     = start_v[0];
  assign bus0.mode      = mode_v[0];
  assign bus0.seed      = seed_v[0];
  assign bus0.out_ready = ready_v[0];
  assign bus1.start     = start_v[1];
  assign bus1.mode      = mode_v[1];
  assign bus1.seed      = seed_v[1];
  assign bus1.out_ready = ready_v[1];

  stim_pattern_gen #(.WIDTH(8), .NUM_VEC(0), .TAPS(8'hB8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  stim_pattern_gen #(.WIDTH(8), .NUM_VEC(4), .TAPS(8'hB8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // ---------------- reference model ----------------
  // The sweep is described by its start value and the number of accepted
  // transfers k, and the vector shown is derived from those.
  typedef struct {
    int         st;     // 0 idle, 1 run, 2 done
    logic [1:0] mode;
    logic [7:0] first;
    longint     k;
    bit         wrap;
    logic [7:0] csum;
  } m_t;

  m_t m [2];

  function automatic logic [7:0] lfsr_step(logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [7:0] seq_val(logic [1:0] md, logic [7:0] first, longint k);
    logic [7:0] v;
    case (md)
      2'b01:   v = first - 8'(k);
      2'b10: begin
        v = first;
        for (longint i = 0; i < k; i++) v = lfsr_step(v);
      end
      default: v = first + 8'(k);
    endcase
    return v;
  endfunction

  function automatic logic [7:0] exp_data(m_t x);
    logic [7:0] v;
    v = seq_val(x.mode, x.first, x.k);
    return (x.mode == 2'b11) ? (v ^ (v >> 1)) : v;
  endfunction

  function automatic logic [31:0] exp_cnt(m_t x);
    return (x.k > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : x.k[31:0];
  endfunction

  function automatic m_t m_next(m_t x, logic st_in, logic [1:0] md, logic [7:0] sd,
                                logic rdy, int nv);
    m_t y;
    logic [7:0] cur;
    y      = x;
    y.wrap = 1'b0;
    if (x.st == 1 && rdy) begin
      cur = seq_val(x.mode, x.first, x.k);
      case (x.mode)
        2'b01:   y.wrap = (cur == 8'h00);
        2'b10:   y.wrap = (seq_val(x.mode, x.first, x.k + 1) == x.first);
        default: y.wrap = (cur == 8'hFF);
      endcase
      y.csum = x.csum + exp_data(x);
      y.k    = x.k + 1;
      if (nv != 0 && y.k == longint'(nv)) y.st = 2;
    end else if (st_in && x.st != 1) begin
      y.st    = 1;
      y.mode  = md;
      y.first = (md == 2'b10 && sd == 8'h00) ? 8'h01 : sd;
      y.k     = 0;
      y.csum  = 8'h00;
    end
    return y;
  endfunction

  // Model update on the same edges as the design
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m[i].st    = 0;
        m[i].mode  = 2'b00;
        m[i].first = 8'h00;
        m[i].k     = 0;
        m[i].wrap  = 1'b0;
        m[i].csum  = 8'h00;
      end else begin
        m[i] = m_next(m[i], start_v[i], mode_v[i], seed_v[i], ready_v[i], (i == 0) ? 0 : 4);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int i, logic [7:0] d, logic v, logic b, logic dn, logic w, logic [31:0] c);
    chk($sformatf("d%0d_out_valid", i), 32'(v),  32'(m[i].st == 1));
    chk($sformatf("d%0d_busy", i),      32'(b),  32'(m[i].st == 1));
    chk($sformatf("d%0d_done", i),      32'(dn), 32'(m[i].st == 2));
    chk($sformatf("d%0d_wrap", i),      32'(w),  32'(m[i].wrap));
    chk($sformatf("d%0d_vec_cnt", i),   c,       exp_cnt(m[i]));
    chk($sformatf("d%0d_out_data", i),  32'(d),  32'(exp_data(m[i])));
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    cmp(0, bus0.out_data, bus0.out_valid, bus0.busy, bus0.done, bus0.wrap, bus0.vec_cnt);
    cmp(1, bus1.out_data, bus1.out_valid, bus1.busy, bus1.done, bus1.wrap, bus1.vec_cnt);
`ifdef STIM_CHECKSUM_EN
    chk("d0_checksum", 32'(bus0.checksum), 32'(m[0].csum));
    chk("d1_checksum", 32'(bus1.checksum), 32'(m[1].csum));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(int i, logic [1:0] md, logic [7:0] sd);
    @(posedge clk); #1;
    start_v[i] = 1'b1;
    mode_v[i]  = md;
    seed_v[i]  = sd;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    // Disturb mode and seed mid-sweep, which must have no effect
    mode_v[i]  = md + 2'd1;
    seed_v[i]  = 8'hA5;
  endtask

  // Asynchronous reset: outputs must clear before the next clock edge
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_valid",   32'(bus0.out_valid), 32'd0);
    chk("rst_busy",    32'(bus0.busy),      32'd0);
    chk("rst_done",    32'(bus0.done),      32'd0);
    chk("rst_wrap",    32'(bus0.wrap),      32'd0);
    chk("rst_vec_cnt", bus0.vec_cnt,        32'd0);
    chk("rst_data",    32'(bus0.out_data),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] e_up   [4];
    logic       w_up   [4];
    logic [7:0] e_down [3];
    logic       w_down [3];
    logic [7:0] e_lfsr [3];
    logic [7:0] e_gray [4];
    logic [31:0] held_cnt;
    bit found;

    e_up   = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    w_up   = '{1'b0, 1'b0, 1'b1, 1'b0};
    e_down = '{8'h01, 8'h00, 8'hFF};
    w_down = '{1'b0, 1'b0, 1'b1};
    e_lfsr = '{8'h01, 8'hB8, 8'h5C};
    e_gray = '{8'h03, 8'h02, 8'h06, 8'h07};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 2'b00;
      seed_v[i]  = 8'h00;
      ready_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_valid",   32'(bus0.out_valid), 32'd0);
    chk("init_vec_cnt", bus1.vec_cnt,        32'd0);

    // UP, free-running, across the all-ones boundary
    ready_v[0] = 1'b1;
    pulse_start(0, 2'b00, 8'hFE);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("up_data%0d", j), 32'(bus0.out_data), 32'(e_up[j]));
      chk($sformatf("up_wrap%0d", j), 32'(bus0.wrap),     32'(w_up[j]));
      chk($sformatf("up_cnt%0d", j),  bus0.vec_cnt,       32'(j));
    end

    // Stall, then start while running, which must be ignored
    ready_v[0] = 1'b0;
    pulse_start(0, 2'b01, 8'h55);
    @(negedge clk);
    chk("ign_start_cnt",  bus0.vec_cnt,        32'd3);
    chk("ign_start_data", 32'(bus0.out_data),  32'h01);
    chk("ign_start_busy", 32'(bus0.busy),      32'd1);

    // Reset while running
    do_reset();

    // DOWN across zero
    ready_v[0] = 1'b1;
    pulse_start(0, 2'b01, 8'h01);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("down_data%0d", j), 32'(bus0.out_data), 32'(e_down[j]));
      chk($sformatf("down_wrap%0d", j), 32'(bus0.wrap),     32'(w_down[j]));
    end
    do_reset();

    // LFSR with zero seed, then wait for the end of the 255-vector period
    pulse_start(0, 2'b10, 8'h00);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("lfsr_data%0d", j), 32'(bus0.out_data), 32'(e_lfsr[j]));
    end
    found = 1'b0;
    for (int j = 0; j < 400 && !found; j++) begin
      @(negedge clk);
      if (bus0.wrap) begin
        found = 1'b1;
        chk("lfsr_wrap_cnt",  bus0.vec_cnt,       32'd255);
        chk("lfsr_wrap_data", 32'(bus0.out_data), 32'h01);
      end
    end
    chk("lfsr_wrap_seen", 32'(found), 32'd1);
    do_reset();

    // GRAY, then stall the sink for three cycles
    pulse_start(0, 2'b11, 8'h02);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("gray_data%0d", j), 32'(bus0.out_data), 32'(e_gray[j]));
    end
    ready_v[0] = 1'b0;
    held_cnt = 32'd3;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("stall_data%0d", j),  32'(bus0.out_data),  32'h07);
      chk($sformatf("stall_cnt%0d", j),   bus0.vec_cnt,        held_cnt);
      chk($sformatf("stall_valid%0d", j), 32'(bus0.out_valid), 32'd1);
    end
    ready_v[0] = 1'b1;
    @(negedge clk);
    chk("resume_data", 32'(bus0.out_data), 32'h05);
    chk("resume_cnt",  bus0.vec_cnt,       32'd4);

    // Bounded sweep of four vectors on dut1
    ready_v[1] = 1'b1;
    pulse_start(1, 2'b00, 8'h00);
    repeat (6) @(negedge clk);
    chk("bnd_valid", 32'(bus1.out_valid), 32'd0);
    chk("bnd_done",  32'(bus1.done),      32'd1);
    chk("bnd_cnt",   bus1.vec_cnt,        32'd4);
    chk("bnd_data",  32'(bus1.out_data),  32'h04);
`ifdef STIM_CHECKSUM_EN
    chk("bnd_checksum", 32'(bus1.checksum), 32'h06);
`endif
    pulse_start(1, 2'b00, 8'h00);
    @(negedge clk);
    chk("restart_done",  32'(bus1.done),      32'd0);
    chk("restart_cnt",   bus1.vec_cnt,        32'd0);
    chk("restart_data",  32'(bus1.out_data),  32'h00);
    chk("restart_valid", 32'(bus1.out_valid), 32'd1);
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
